// File: rtl/keypad_scanner.sv
// Column-scanning keypad front end: synchronizes the row lines, walks a one-hot
// column drive and freezes on a pressed column until every row is released.
module keypad_scanner #(
    parameter logic [3:0] SCAN_DIV = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] rcBits,
    output logic       holding
);

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_rows_s1;
    logic [3:0] r_rows_s2;
    logic [3:0] r_cnt;
    logic [3:0] r_cols;
    logic [3:0] w_cols_nxt;
    logic [7:0] r_rcbits;
    logic       w_tick;
    logic       w_row_act;

    assign w_tick    = (r_cnt == (SCAN_DIV - 4'd1));
    assign w_row_act = (r_rows_s2 != 4'd0);
    assign cols      = r_cols;
    assign rcBits    = r_rcbits;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rows_s1 <= 4'd0;
            r_rows_s2 <= 4'd0;
        end else begin
            r_rows_s1 <= rows;
            r_rows_s2 <= r_rows_s1;
        end
    end

    // Free-running dwell counter; it never stalls, even while holding
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_tick) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // State register together with the column drive and the evaluator sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_SCAN;
            r_cols   <= 4'b0001;
            r_rcbits <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cols  <= w_cols_nxt;
            if (w_tick) begin
                // sample uses the column as it was before this tick's rotation
                r_rcbits <= {r_rows_s2, r_cols};
            end else begin
                r_rcbits <= r_rcbits;
            end
        end
    end

    // Next-state and next-column decision, evaluated only on a dwell tick
    always_comb begin
        w_state_nxt = r_state;
        w_cols_nxt  = r_cols;
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_row_act) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_cols_nxt = {r_cols[2:0], r_cols[3]};
                    end
                end
                ST_HOLD: begin
                    if (w_row_act) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_SCAN;
                    end
                end
                default: begin
                    w_state_nxt = ST_SCAN;
                    w_cols_nxt  = 4'b0001;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_cols_nxt  = r_cols;
        end
    end

    // Output decode straight from the state register
    always_comb begin
        holding = (r_state == ST_HOLD);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed + randomized bench for keypad_scanner against a behavioural model
// built from column index, dwell phase and a short row history.
module tb_keypad_scanner;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] rcBits;
    logic       holding;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int         m_phase = 0;
    int         m_col   = 0;
    bit         m_hold  = 1'b0;
    logic [7:0] m_rc    = 8'h00;
    logic [3:0] m_h1    = 4'd0;
    logic [3:0] m_h2    = 4'd0;

    keypad_scanner #(.SCAN_DIV(4'd4)) dut (
        .clk    (clk),
        .reset  (reset),
        .rows   (rows),
        .cols   (cols),
        .rcBits (rcBits),
        .holding(holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_onehot(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        bit tick;
        if (!reset) begin
            m_phase = 0;
            m_col   = 0;
            m_hold  = 1'b0;
            m_rc    = 8'h00;
            m_h1    = 4'd0;
            m_h2    = 4'd0;
        end else begin
            tick = (m_phase == DIV - 1);
            if (tick) begin
                m_rc = {m_h2, col_onehot(m_col)};
                if (!m_hold && m_h2 == 4'd0) m_col = (m_col + 1) % 4;
                m_hold = (m_h2 != 4'd0);
            end
            m_phase = (m_phase + 1) % DIV;
            m_h2    = m_h1;
            m_h1    = rows;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("cols",    {4'd0, cols},    {4'd0, col_onehot(m_col)});
        check("rcBits",  rcBits,          m_rc);
        check("holding", {7'd0, holding}, {7'd0, m_hold});
    endtask

    // Run until the model has just passed a tick edge
    task automatic wait_tick();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (m_phase != 0 && k < 40);
        check("wait_tick_bound", {7'd0, (m_phase == 0)}, 8'd1);
    endtask

    // Run until the given column has just become active
    task automatic wait_col(input int c);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!(m_col == c && m_phase == 0) && k < 200);
        check("wait_col_bound", {7'd0, (m_col == c && m_phase == 0)}, 8'd1);
    endtask

    initial begin
        reset = 1'b0;
        rows  = 4'd0;
        cycle();
        cycle();
        check("rst_cols", {4'd0, cols}, 8'h01);
        check("rst_rc", rcBits, 8'h00);
        check("rst_hold", {7'd0, holding}, 8'd0);

        // idle scan
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cycle();

        // press on column 0100, row 0010
        wait_col(2);
        rows = 4'b0010;
        wait_tick();
        check("press_rc", rcBits, 8'h24);
        check("press_hold", {7'd0, holding}, 8'd1);
        wait_tick();
        check("press_cols_frozen", {4'd0, cols}, 8'h04);

        // release
        rows = 4'd0;
        wait_tick();
        check("release_rc", rcBits, 8'h04);
        check("release_hold", {7'd0, holding}, 8'd0);
        wait_tick();
        check("release_rotate", {4'd0, cols}, 8'h08);

        // one-cycle glitch right after a tick never reaches the tick sample
        rows = 4'b1000;
        cycle();
        rows = 4'd0;
        wait_tick();
        check("glitch_hold", {7'd0, holding}, 8'd0);
        check("glitch_rows", {4'd0, rcBits[7:4]}, 8'h00);
        check("glitch_cols", {4'd0, cols}, 8'h01);

        // multi-key on column 0001
        rows = 4'b0101;
        wait_tick();
        check("multi_rc", rcBits, 8'h51);
        check("multi_hold", {7'd0, holding}, 8'd1);
        rows = 4'b0100;
        wait_tick();
        check("multi_partial_rc", rcBits, 8'h41);
        check("multi_partial_hold", {7'd0, holding}, 8'd1);

        // reset while holding on column 1000
        rows = 4'd0;
        wait_tick();
        wait_col(3);
        rows = 4'b0010;
        wait_tick();
        check("hold_1000_rc", rcBits, 8'h28);
        cycle();
        reset = 1'b0;
        cycle();
        check("midhold_rst_cols", {4'd0, cols}, 8'h01);
        check("midhold_rst_rc", rcBits, 8'h00);
        check("midhold_rst_hold", {7'd0, holding}, 8'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("pre_first_tick_hold", {7'd0, holding}, 8'd0);
        end
        cycle();
        check("first_tick_hold", {7'd0, holding}, 8'd1);
        check("first_tick_rc", rcBits, 8'h21);

        // randomized rows with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)
                rows = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
